// File: rtl/ad4003_pkg.sv
// Shared definitions for the AD4003 acquisition path: sample width, control states and the
// packed AXI-Stream word layout used by the deserializer and downstream unpacking.
package ad4003_pkg;

  localparam int unsigned ADC_DATA_WIDTH = 18;

  // Stream word layout: {ch[5:0], frame[7:0], sample[17:0]}
  localparam int unsigned CH_LSB   = 26;
  localparam int unsigned FCNT_LSB = 18;
  localparam int unsigned FCNT_W   = 8;
  localparam int unsigned DATA_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    WAIT_FRM,
    SEND
  } acq_state_e;

endpackage

// File: rtl/ad4003_trig_detect.sv
// Start-pulse generation for an armed acquisition: immediate start or rising edge of hw_trig.
module ad4003_trig_detect (
  input  logic adc_read_clk,
  input  logic rst,
  input  logic armed,
  input  logic trig_sel,
  input  logic hw_trig,
  output logic start
);

  logic hw_trig_q;

  // Tracks hw_trig continuously so a level already high at arm time is never seen as an edge.
  always_ff @(posedge adc_read_clk or posedge rst) begin
    if (rst) begin
      hw_trig_q <= 1'b0;
    end else begin
      hw_trig_q <= hw_trig;
    end
  end

  always_comb begin
    start = armed & (~trig_sel | (hw_trig & ~hw_trig_q));
  end

endmodule

// File: rtl/ad4003_acq_ctrl.sv
// Acquisition controller: arms, triggers, decimates conversion frames and streams every channel
// of each kept frame as one 32-bit AXI-Stream word, with run-length and overrun tracking.
module ad4003_acq_ctrl
  import ad4003_pkg::*;
#(
  parameter int unsigned ADC_CHANNELS = 8,
  parameter int unsigned CH_IDX_W     = 6
) (
  input  logic                                   adc_read_clk,
  input  logic                                   rst,
  input  logic [ADC_DATA_WIDTH*ADC_CHANNELS-1:0] adc_data_arr,
  input  logic                                   adc_frame_strb,
  input  logic                                   arm,
  input  logic                                   stop,
  input  logic                                   trig_sel,
  input  logic                                   hw_trig,
  input  logic [15:0]                            cfg_decim,
  input  logic [31:0]                            cfg_nframes,
  output logic [31:0]                            m_axis_tdata,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic                                   m_axis_tlast,
  output logic                                   busy,
  output logic                                   armed,
  output logic                                   done,
  output logic                                   overrun,
  output logic [31:0]                            frame_count
);

  localparam int unsigned IDX_W = (ADC_CHANNELS > 1) ? $clog2(ADC_CHANNELS) : 1;
  localparam logic [CH_IDX_W-1:0] LAST_CH = CH_IDX_W'(ADC_CHANNELS - 1);

  acq_state_e state_q, state_d;
  logic [CH_IDX_W-1:0]       ch_idx_q, ch_idx_d;
  logic [31:0]               frame_count_q, frame_count_d;
  logic [15:0]               decim_cnt_q, decim_cnt_d;
  logic                      stop_pending_q, stop_pending_d;
  logic                      done_q, done_d;
  logic                      overrun_q, overrun_d;
  logic                      trig_sel_q;
  logic [15:0]               cfg_decim_q;
  logic [31:0]               cfg_nframes_q;
  logic [ADC_DATA_WIDTH-1:0] snapshot_q [ADC_CHANNELS];
  logic                      load_cfg;
  logic                      capture;
  logic                      start;
  logic                      beat;
  logic                      last_ch;
  logic [IDX_W-1:0]          ch_sel;

  ad4003_trig_detect u_trig_detect (
    .adc_read_clk (adc_read_clk),
    .rst          (rst),
    .armed        (state_q == ARMED),
    .trig_sel     (trig_sel_q),
    .hw_trig      (hw_trig),
    .start        (start)
  );

  always_comb begin
    beat    = (state_q == SEND) && m_axis_tready;
    last_ch = (ch_idx_q == LAST_CH);
    ch_sel  = ch_idx_q[IDX_W-1:0];
  end

  always_comb begin
    state_d        = state_q;
    ch_idx_d       = ch_idx_q;
    frame_count_d  = frame_count_q;
    decim_cnt_d    = decim_cnt_q;
    stop_pending_d = stop_pending_q;
    done_d         = done_q;
    overrun_d      = overrun_q;
    load_cfg       = 1'b0;
    capture        = 1'b0;

    if (adc_frame_strb && (state_q == WAIT_FRM || state_q == SEND)) begin
      decim_cnt_d = (decim_cnt_q == cfg_decim_q) ? 16'd0 : decim_cnt_q + 16'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (arm) begin
          load_cfg       = 1'b1;
          done_d         = 1'b0;
          overrun_d      = 1'b0;
          frame_count_d  = 32'd0;
          decim_cnt_d    = 16'd0;
          stop_pending_d = 1'b0;
          state_d        = ARMED;
        end
      end
      ARMED: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = WAIT_FRM;
        end
      end
      WAIT_FRM: begin
        if (stop) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (adc_frame_strb && decim_cnt_q == 16'd0) begin
          capture  = 1'b1;
          ch_idx_d = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (stop) begin
          stop_pending_d = 1'b1;
        end
        if (adc_frame_strb) begin
          overrun_d = 1'b1;
        end
        if (beat) begin
          if (last_ch) begin
            frame_count_d = frame_count_q + 32'd1;
            ch_idx_d      = '0;
            // A stop arriving on the final beat itself also ends the run.
            if (stop_pending_q || stop ||
                (cfg_nframes_q != 32'd0 && frame_count_q + 32'd1 == cfg_nframes_q)) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = WAIT_FRM;
            end
          end else begin
            ch_idx_d = ch_idx_q + CH_IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge adc_read_clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      ch_idx_q       <= '0;
      frame_count_q  <= 32'd0;
      decim_cnt_q    <= 16'd0;
      stop_pending_q <= 1'b0;
      done_q         <= 1'b0;
      overrun_q      <= 1'b0;
      trig_sel_q     <= 1'b0;
      cfg_decim_q    <= 16'd0;
      cfg_nframes_q  <= 32'd0;
    end else begin
      state_q        <= state_d;
      ch_idx_q       <= ch_idx_d;
      frame_count_q  <= frame_count_d;
      decim_cnt_q    <= decim_cnt_d;
      stop_pending_q <= stop_pending_d;
      done_q         <= done_d;
      overrun_q      <= overrun_d;
      if (load_cfg) begin
        trig_sel_q    <= trig_sel;
        cfg_decim_q   <= cfg_decim;
        cfg_nframes_q <= cfg_nframes;
      end
    end
  end

  always_ff @(posedge adc_read_clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < ADC_CHANNELS; k++) begin
        snapshot_q[k] <= '0;
      end
    end else if (capture) begin
      for (int k = 0; k < ADC_CHANNELS; k++) begin
        snapshot_q[k] <= adc_data_arr[k*ADC_DATA_WIDTH +: ADC_DATA_WIDTH];
      end
    end
  end

  always_comb begin
    m_axis_tdata                                   = '0;
    m_axis_tdata[CH_LSB +: CH_IDX_W]               = ch_idx_q;
    m_axis_tdata[FCNT_LSB +: FCNT_W]               = frame_count_q[FCNT_W-1:0];
    m_axis_tdata[DATA_LSB +: ADC_DATA_WIDTH]       = snapshot_q[ch_sel];
    m_axis_tvalid                                  = (state_q == SEND);
    m_axis_tlast                                   = (state_q == SEND) && last_ch;
    busy                                           = (state_q != IDLE);
    armed                                          = (state_q == ARMED);
    done                                           = done_q;
    overrun                                        = overrun_q;
    frame_count                                    = frame_count_q;
  end

endmodule

// File: tb/tb_ad4003_acq_ctrl.sv
// Scoreboard bench for ad4003_acq_ctrl: expected stream words are queued when a captured
// strobe is driven and compared beat-by-beat as the DUT hands them over.
`timescale 1ns / 1ps
module tb_ad4003_acq_ctrl;

  localparam int NCH = 8;
  localparam int DW  = 18;

  logic              adc_read_clk = 1'b0;
  logic              rst = 1'b1;
  logic [DW*NCH-1:0] adc_data_arr = '0;
  logic              adc_frame_strb = 1'b0;
  logic              arm = 1'b0;
  logic              stop = 1'b0;
  logic              trig_sel = 1'b0;
  logic              hw_trig = 1'b0;
  logic [15:0]       cfg_decim = '0;
  logic [31:0]       cfg_nframes = '0;
  logic [31:0]       m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              m_axis_tlast;
  logic              busy;
  logic              armed;
  logic              done;
  logic              overrun;
  logic [31:0]       frame_count;

  logic [32:0] sb_q [$];
  logic [31:0] obs_q [$];
  int          errors = 0;
  int          checks = 0;
  int          beat_cnt = 0;
  int          tlast_cnt = 0;
  int          exp_frame = 0;
  int          base_beats;
  int          base_tlast;

  ad4003_acq_ctrl #(
    .ADC_CHANNELS (NCH),
    .CH_IDX_W     (6)
  ) dut (
    .adc_read_clk   (adc_read_clk),
    .rst            (rst),
    .adc_data_arr   (adc_data_arr),
    .adc_frame_strb (adc_frame_strb),
    .arm            (arm),
    .stop           (stop),
    .trig_sel       (trig_sel),
    .hw_trig        (hw_trig),
    .cfg_decim      (cfg_decim),
    .cfg_nframes    (cfg_nframes),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .busy           (busy),
    .armed          (armed),
    .done           (done),
    .overrun        (overrun),
    .frame_count    (frame_count)
  );

  always #5 adc_read_clk = ~adc_read_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge adc_read_clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      logic [32:0] exp_word;
      beat_cnt++;
      if (m_axis_tlast) tlast_cnt++;
      obs_q.push_back(m_axis_tdata);
      check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        exp_word = sb_q.pop_front();
        check("beat", {31'd0, m_axis_tlast, m_axis_tdata}, {31'd0, exp_word});
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge adc_read_clk);
    #1;
  endtask

  // Config inputs are scrambled after arm so any failure to latch them shows up.
  task automatic do_arm(input logic tsel, input logic [15:0] decim, input logic [31:0] nfr);
    @(posedge adc_read_clk); #1;
    trig_sel    = tsel;
    cfg_decim   = decim;
    cfg_nframes = nfr;
    arm         = 1'b1;
    @(posedge adc_read_clk); #1;
    arm         = 1'b0;
    trig_sel    = ~tsel;
    cfg_decim   = 16'hffff;
    cfg_nframes = 32'd1;
    exp_frame   = 0;
  endtask

  task automatic do_stop();
    @(posedge adc_read_clk); #1;
    stop = 1'b1;
    @(posedge adc_read_clk); #1;
    stop = 1'b0;
  endtask

  task automatic strobe(input bit cap, input logic [17:0] base);
    @(posedge adc_read_clk); #1;
    for (int k = 0; k < NCH; k++) adc_data_arr[k*DW +: DW] = base + 18'(k);
    adc_frame_strb = 1'b1;
    if (cap) begin
      for (int k = 0; k < NCH; k++) begin
        sb_q.push_back({(k == NCH - 1), 6'(k), 8'(exp_frame), 18'(base + 18'(k))});
      end
      exp_frame++;
    end
    @(posedge adc_read_clk); #1;
    adc_frame_strb = 1'b0;
    if (cap) check("latency_tvalid", 64'(m_axis_tvalid), 64'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 2000) begin
      @(negedge adc_read_clk);
      n++;
    end
    check("drain", 64'(sb_q.size()), 64'd0);
    @(posedge adc_read_clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int obs_base;

    // Reset state
    cycles(3);
    rst = 1'b0;
    cycles(1);
    check("rst_busy", 64'(busy), 0);
    check("rst_armed", 64'(armed), 0);
    check("rst_done", 64'(done), 0);
    check("rst_overrun", 64'(overrun), 0);
    check("rst_fcnt", 64'(frame_count), 0);
    check("rst_tvalid", 64'(m_axis_tvalid), 0);
    check("rst_tlast", 64'(m_axis_tlast), 0);

    // Three-frame run, no decimation
    base_beats = beat_cnt;
    base_tlast = tlast_cnt;
    obs_base   = obs_q.size();
    do_arm(1'b0, 16'd0, 32'd3);
    cycles(3);
    for (int f = 0; f < 3; f++) begin
      strobe(1'b1, 18'h1000);
      cycles(39);
    end
    wait_drain();
    check("t1_beats", 64'(beat_cnt - base_beats), 64'd24);
    check("t1_tlasts", 64'(tlast_cnt - base_tlast), 64'd3);
    if (obs_q.size() > obs_base + 8) check("t1_f1w0", 64'(obs_q[obs_base + 8]), 64'h0004_1000);
    else check("t1_f1w0_present", 64'(obs_q.size()), 64'(obs_base + 9));
    check("t1_done", 64'(done), 1);
    check("t1_fcnt", 64'(frame_count), 3);
    check("t1_busy", 64'(busy), 0);

    // Decimate by 3, continuous
    do_arm(1'b0, 16'd2, 32'd0);
    check("t2_armed_or_wait", 64'(busy), 1);
    check("t2_done_cleared", 64'(done), 0);
    cycles(3);
    for (int s = 0; s < 9; s++) begin
      strobe(s % 3 == 0, 18'h2000 + 18'(s * 16));
      cycles(39);
    end
    wait_drain();
    check("t2_fcnt", 64'(frame_count), 3);
    check("t2_busy_run", 64'(busy), 1);
    do_stop();
    cycles(1);
    check("t2_done", 64'(done), 1);
    check("t2_idle", 64'(busy), 0);

    // Hardware trigger, level high at arm must not start
    hw_trig = 1'b1;
    cycles(3);
    do_arm(1'b1, 16'd0, 32'd0);
    cycles(5);
    check("t3_still_armed", 64'(armed), 1);
    strobe(1'b0, 18'h3000);
    cycles(3);
    check("t3_no_tvalid", 64'(m_axis_tvalid), 0);
    hw_trig = 1'b0;
    cycles(4);
    check("t3_armed_after_fall", 64'(armed), 1);
    hw_trig = 1'b1;
    cycles(2);
    check("t3_triggered", 64'(armed), 0);
    check("t3_busy", 64'(busy), 1);
    strobe(1'b1, 18'h3100);
    wait_drain();
    check("t3_fcnt", 64'(frame_count), 1);
    do_stop();
    hw_trig = 1'b0;

    // Backpressure with overrun
    do_arm(1'b0, 16'd0, 32'd0);
    check("t4_overrun_cleared", 64'(overrun), 0);
    cycles(3);
    strobe(1'b1, 18'h0a00);
    cycles(2);
    m_axis_tready = 1'b0;
    cycles(1);
    check("t4_hold_tvalid", 64'(m_axis_tvalid), 1);
    check("t4_hold_word", {31'd0, m_axis_tlast, m_axis_tdata}, {31'd0, sb_q[0]});
    cycles(20);
    strobe(1'b0, 18'h0b00);
    cycles(1);
    check("t4_overrun", 64'(overrun), 1);
    cycles(25);
    check("t4_hold_tvalid2", 64'(m_axis_tvalid), 1);
    check("t4_hold_word2", {31'd0, m_axis_tlast, m_axis_tdata}, {31'd0, sb_q[0]});
    m_axis_tready = 1'b1;
    wait_drain();
    cycles(5);
    strobe(1'b1, 18'h0c00);
    wait_drain();
    check("t4_fcnt", 64'(frame_count), 2);
    check("t4_overrun_sticky", 64'(overrun), 1);
    do_stop();

    // Stop mid-frame
    do_arm(1'b0, 16'd0, 32'd0);
    check("t5_arm_overrun", 64'(overrun), 0);
    check("t5_arm_done", 64'(done), 0);
    check("t5_arm_fcnt", 64'(frame_count), 0);
    cycles(3);
    base_tlast = tlast_cnt;
    strobe(1'b1, 18'h0d00);
    cycles(2);
    do_stop();
    wait_drain();
    check("t5_tlast", 64'(tlast_cnt - base_tlast), 1);
    check("t5_idle", 64'(busy), 0);
    check("t5_done", 64'(done), 1);
    check("t5_fcnt", 64'(frame_count), 1);
    do_arm(1'b0, 16'd0, 32'd0);
    check("t5_rearm_done", 64'(done), 0);
    check("t5_rearm_fcnt", 64'(frame_count), 0);

    // Asynchronous reset in the middle of a frame
    cycles(3);
    strobe(1'b1, 18'h0e00);
    cycles(2);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_tvalid", 64'(m_axis_tvalid), 0);
    check("t6_rst_busy", 64'(busy), 0);
    check("t6_rst_fcnt", 64'(frame_count), 0);
    sb_q.delete();
    cycles(2);
    rst = 1'b0;
    obs_base = obs_q.size();
    do_arm(1'b0, 16'd0, 32'd0);
    cycles(3);
    strobe(1'b1, 18'h0f00);
    wait_drain();
    if (obs_q.size() > obs_base) check("t6_frame_field", 64'(obs_q[obs_base][25:18]), 64'd0);
    else check("t6_first_word_present", 64'(obs_q.size()), 64'(obs_base + 1));
    check("t6_fcnt", 64'(frame_count), 1);
    do_stop();
    cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ad4003_acq_ctrl.md
Name: ad4003_acq_ctrl

Overview:
- Acquisition controller for the AD4003 deserializer bank.
- Arms on software command and starts on a software or hardware trigger.
- On each completed conversion frame, decimates, snapshots all channels and serialises them as 32-bit AXI-Stream words, one word per channel, toward the DMA/packetiser.
- Counts frames, stops on frame limit or stop command, and flags overruns.

Parameters:
- ADC_CHANNELS, 8: channel count, even, max 48.
- ADC_DATA_WIDTH, 18: sample width; fixed, not to be overridden.
- CH_IDX_W, 6: channel-index field width.

Ports:
- adc_read_clk  in  1  sole clock (80 MHz read domain).
- rst  in  1  asynchronous, active-high reset.
- adc_data_arr  in  ADC_DATA_WIDTH*ADC_CHANNELS  packed samples; channel k at bits [18k +: 18].
- adc_frame_strb  in  1  one-cycle pulse; adc_data_arr valid that cycle and stable ≥40 cycles after.
- arm  in  1  pulse; start a run.
- stop  in  1  pulse; end the run.
- trig_sel  in  1  0 = immediate start, 1 = wait for hw_trig.
- hw_trig  in  1  synchronous hardware trigger; rising edge used.
- cfg_decim  in  16  keep 1 of every cfg_decim+1 frames.
- cfg_nframes  in  32  frames per run; 0 = continuous.
- m_axis_tdata  out  32  {ch[5:0], frame_cnt[7:0], sample[17:0]}.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tready  in  1  AXI-Stream ready.
- m_axis_tlast  out  1  asserted on the last channel of each frame.
- busy  out  1  state != IDLE.
- armed  out  1  state == ARMED.
- done  out  1  sticky; run completed.
- overrun  out  1  sticky; frame dropped while sending.
- frame_count  out  32  frames emitted this run.

Behaviour:
- Reset values: state=IDLE; all outputs 0; decim_cnt=0; stop_pending=0; snapshot=0.
- Config sampling: trig_sel, cfg_decim and cfg_nframes are latched on arm in IDLE. Later changes are ignored until the next arm.
- IDLE:
  - arm clears done, overrun, frame_count, decim_cnt and stop_pending, then goes to ARMED.
  - stop in IDLE is ignored. arm+stop in the same cycle = arm.
- ARMED:
  - stop -> IDLE; done is not set.
  - trig_sel=0 -> WAIT_FRM next cycle.
  - trig_sel=1 -> WAIT_FRM on the cycle after the hw_trig rising edge (hw_trig & ~hw_trig_q).
  - hw_trig already high when arm arrives does not count as a trigger.
- WAIT_FRM:
  - strb with decim_cnt==0: latch adc_data_arr, ch_idx=0, -> SEND.
  - decim_cnt advances on every strb (WAIT_FRM or SEND) and wraps from cfg_decim to 0.
  - stop -> IDLE, done=1.
- SEND:
  - tvalid=1; tdata = {ch_idx, frame_count[7:0], snapshot[ch_idx]}.
  - Each tvalid&&tready beat increments ch_idx.
  - tlast=1 when ch_idx==ADC_CHANNELS-1.
  - Once asserted, tvalid and tdata hold until accepted (AXIS rule). tvalid is never dropped by stop.
  - Last beat accepted: frame_count++. Then:
    - stop_pending, or cfg_nframes!=0 and frame_count+1==cfg_nframes -> IDLE, done=1.
    - otherwise -> WAIT_FRM.
  - stop during SEND sets stop_pending; the current frame completes.
  - strb during SEND sets overrun=1; that frame is not captured. Always hit when ADC_CHANNELS>40 at full tready, or under backpressure.
- Latency: strb at cycle T -> first beat valid at T+1 (registered snapshot and state).
- Arithmetic and wrap: frame_count wraps at 2^32. With cfg_nframes=0 the run continues past the wrap. The tdata frame field is the low 8 bits and wraps silently.
- arm outside IDLE is ignored.
- rst mid-operation: everything returns to reset values immediately, including tvalid. A partial frame is abandoned with no tlast.

Decomposition:
- Package ad4003_pkg:
  - ADC_DATA_WIDTH=18.
  - State enum IDLE/ARMED/WAIT_FRM/SEND.
  - tdata field offsets: CH_LSB=26, FCNT_LSB=18, DATA_LSB=0.
  - Shared with ad4003_deserializer and downstream unpacking.
- Sub-module ad4003_trig_detect: hw_trig edge register, trig_sel mux, one-cycle start pulse output.

Test Plan:
- ADC_CHANNELS=8, trig_sel=0, cfg_nframes=3, cfg_decim=0, tready=1, strb every 40 cycles, ch k = 18'h1000+k:
  - exactly 24 beats; word 0 of frame 1 = 32'h0004_1000.
  - tlast on beats 8/16/24.
  - done=1 and frame_count=3 after beat 24; busy=0.
- cfg_decim=2, 9 strobes, continuous: frames from strobes 1, 4 and 7 only (frame_count=3); stop then -> done=1, state IDLE.
- trig_sel=1, hw_trig held high before arm: no output. hw_trig falls, then rises at cycle 100 -> first strb after cycle 101 is captured.
- tready=0 for 50 cycles mid-frame: tdata/tvalid held stable, next strb sets overrun=1, resumed beats carry the original frame; the following frame is correct.
- stop during beat 3 of a frame: remaining 5 beats emitted with tlast, then IDLE, done=1. A subsequent arm clears done, overrun and frame_count.
- rst asserted mid-SEND: tvalid=0 and busy=0 immediately. arm after release starts a clean run with frame field 0.
